// File: rtl/nurn_step_sched.sv
// nurn_step_sched: time-step scheduler for one neuron core.
// Issues start pulses, times the window, buffers spikes to the router.
module nurn_step_sched #(
  parameter int AER_BIT_WIDTH      = 32,
  parameter int STEP_CYCLES        = 16,
  parameter int STEP_CNT_BIT_WIDTH = 5,
  parameter int FIFO_DEPTH         = 4,
  parameter int FIFO_PTR_BIT_WIDTH = 2,
  parameter int DROP_CNT_BIT_WIDTH = 8,
  parameter int TSTEP_BIT_WIDTH    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          tick_i,
  output logic                          start_o,
  input  logic                          outSpike_i,
  input  logic [AER_BIT_WIDTH-1:0]      SpikePacket_i,
  output logic                          pkt_valid_o,
  output logic [AER_BIT_WIDTH-1:0]      pkt_data_o,
  input  logic                          pkt_ready_i,
  output logic                          busy_o,
  output logic                          overrun_o,
  input  logic                          overrun_clr_i,
  output logic [DROP_CNT_BIT_WIDTH-1:0] drop_cnt_o,
  output logic [TSTEP_BIT_WIDTH-1:0]    tstep_o,
  output logic [FIFO_PTR_BIT_WIDTH:0]   fifo_cnt_o
);

  localparam int CW = STEP_CNT_BIT_WIDTH;
  localparam int PW = FIFO_PTR_BIT_WIDTH;

  localparam logic [CW-1:0] LAST_C  = CW'(STEP_CYCLES - 1);
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_start;
  logic                    r_busy;
  logic [CW-1:0]           r_cnt;
  logic [TSTEP_BIT_WIDTH-1:0] r_tstep;
  logic                    r_ovr;
  logic [DROP_CNT_BIT_WIDTH-1:0] r_drop;

  logic [AER_BIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wp;
  logic [PW-1:0]           r_rp;
  logic [PW:0]             r_fcnt;

  logic                    w_ovr_set;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_wr;
  logic                    w_drop;

  // next-state decode for the step sequencer
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (tick_i) w_next = S_START;
      S_START: w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST_C) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state plus registered start/busy outputs derived from next state
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= (w_next == S_START);
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // window counter: cleared in START, counts through RUN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (r_state == S_START) begin
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // step counter advances as START is entered, so it reads new in START
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_tstep <= '0;
    end else if (r_state == S_IDLE && tick_i) begin
      r_tstep <= r_tstep + 1'b1;
    end
  end

  assign w_ovr_set = tick_i && (r_state != S_IDLE);

  // sticky overrun flag, set beats clear
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ovr <= 1'b0;
    end else if (w_ovr_set) begin
      r_ovr <= 1'b1;
    end else if (overrun_clr_i) begin
      r_ovr <= 1'b0;
    end
  end

  assign w_push = (r_state == S_RUN) && outSpike_i;
  assign w_pop  = (r_fcnt != '0) && pkt_ready_i;
  assign w_full = (r_fcnt == DEPTH_C);
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  // FIFO storage; cleared on reset so the head reads zero
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wp] <= SpikePacket_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // saturating count of spikes lost to a full FIFO
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != '1)) begin
      r_drop <= r_drop + 1'b1;
    end
  end

  assign start_o     = r_start;
  assign busy_o      = r_busy;
  assign overrun_o   = r_ovr;
  assign tstep_o     = r_tstep;
  assign drop_cnt_o  = r_drop;
  assign fifo_cnt_o  = r_fcnt;
  assign pkt_valid_o = (r_fcnt != '0);
  assign pkt_data_o  = r_mem[r_rp];

endmodule

// File: doc/nurn_step_sched.md
Name: nurn_step_sched

Overview:
- Time-step scheduler for one neuron core.
- On each global tick it issues a one-cycle start pulse to the neuron core, then holds off for a fixed processing window of STEP_CYCLES cycles.
- During the window it captures every asserted outSpike together with the current SpikePacket into an output FIFO, which drains to the router over a valid/ready handshake.
- It also detects tick overruns and counts packets dropped because the FIFO was full.

Parameters:
- AER_BIT_WIDTH, 32: width of the spike packet (AER word).
- STEP_CYCLES, 16: length of the processing window in clocks, counted from the cycle after start_o. Must be ≥ 2.
- STEP_CNT_BIT_WIDTH, 5: window counter width. Must hold STEP_CYCLES-1.
- FIFO_DEPTH, 4: output FIFO entries. Power of two.
- FIFO_PTR_BIT_WIDTH, 2: log2(FIFO_DEPTH).
- DROP_CNT_BIT_WIDTH, 8: width of the saturating drop counter.
- TSTEP_BIT_WIDTH, 16: width of the time-step counter.

Ports:
- clk_i  in  1  single clock; all logic is rising-edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- tick_i  in  1  global time-step tick, one-cycle pulse.
- start_o  out  1  start pulse to the neuron core.
- outSpike_i  in  1  neuron core fired this cycle.
- SpikePacket_i  in  AER_BIT_WIDTH  AER word accompanying outSpike_i.
- pkt_valid_o  out  1  FIFO head valid toward the router.
- pkt_data_o  out  AER_BIT_WIDTH  FIFO head data (show-ahead).
- pkt_ready_i  in  1  router accepts the head this cycle.
- busy_o  out  1  state is not IDLE.
- overrun_o  out  1  sticky: a tick arrived while busy.
- overrun_clr_i  in  1  clears overrun_o.
- drop_cnt_o  out  DROP_CNT_BIT_WIDTH  packets lost because the FIFO was full; saturates.
- tstep_o  out  TSTEP_BIT_WIDTH  count of steps started; wraps.
- fifo_cnt_o  out  FIFO_PTR_BIT_WIDTH+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n_i=0 sampled at an edge):
  - state=IDLE.
  - start_o, pkt_valid_o, busy_o, overrun_o = 0.
  - drop_cnt_o, tstep_o, fifo_cnt_o = 0; FIFO pointers = 0.
  - pkt_data_o = 0.
  - Reset mid-window aborts the step immediately; FIFO contents are discarded.
- State machine, three states:
  - IDLE: tick_i=1 → START.
  - START: start_o=1 for exactly this cycle; tstep_o increments (wraps); window counter cleared; next state RUN.
  - RUN: counter increments each cycle; when counter == STEP_CYCLES-1 → IDLE. RUN therefore lasts exactly STEP_CYCLES cycles.
- start_o is registered. It goes high the cycle after tick_i is sampled in IDLE, so tick-to-start latency is 1 cycle.
- busy_o = (state != IDLE), registered with state.
- Tick while busy:
  - tick_i=1 in START or RUN is dropped, never queued, and sets overrun_o.
  - A tick on the final RUN cycle is also dropped; the next tick is honoured only from IDLE.
  - If overrun_clr_i and a setting event coincide, set wins.
- Spike capture:
  - Push when state==RUN and outSpike_i=1.
  - outSpike_i in IDLE or START is ignored and not counted as a drop.
- FIFO:
  - Synchronous, show-ahead. pkt_valid_o = occupancy ≠ 0; pkt_data_o = head entry.
  - Pop when pkt_valid_o & pkt_ready_i.
  - Push-to-visible latency is 1 cycle. There is no bypass: a push into an empty FIFO is visible the next cycle.
  - Full, push with no pop: packet dropped; drop_cnt_o increments, saturating at all-ones.
  - Full, push and pop in the same cycle: both performed, no drop, occupancy unchanged.
  - Empty, pop requested: impossible, since valid=0; pkt_ready_i is ignored.
  - Pointers wrap modulo FIFO_DEPTH. fifo_cnt_o ranges 0..FIFO_DEPTH.
- The router may stall arbitrarily. Scheduling never waits on FIFO drain; the FIFO continues draining while the state is IDLE.
- pkt_data_o is stable while pkt_valid_o=1 and pkt_ready_i=0.

Test Plan:
- Reset then single tick, STEP_CYCLES=16 → start_o high exactly 1 cycle, 1 cycle after the tick. busy_o high 17 cycles (START plus 16 RUN). tstep_o=1.
- In RUN, outSpike_i=1 on 3 cycles with packets 0xA, 0xB, 0xC; pkt_ready_i=1 → pkt_data_o presents 0xA, 0xB, 0xC in order, each valid 1 cycle after its push. drop_cnt_o=0.
- pkt_ready_i=0, 6 spikes in one window (FIFO_DEPTH=4) → fifo_cnt_o=4, drop_cnt_o=2, first 4 packets retained. Then ready=1 → 4 pops, then pkt_valid_o=0.
- FIFO full, push and pop in the same cycle → fifo_cnt_o stays 4, drop_cnt_o unchanged, new packet appears after the 3 older entries.
- tick_i at RUN cycle 5 → no second start_o, overrun_o=1 and held; overrun_clr_i pulse → overrun_o=0. Following tick in IDLE → normal start, tstep_o=2.
- rst_n_i=0 for 1 cycle at RUN cycle 8 with 2 packets queued → next cycle state IDLE, busy_o=0, fifo_cnt_o=0, pkt_valid_o=0, tstep_o=0.
